// File: rtl/write_back_pkg.sv
// Shared widths, write-select codes and FSM encodings for the write-back stage.
package write_back_pkg;
  localparam int LENGTH = 16;
  localparam int INT8   = 8;
  localparam int INT32  = 32;
  localparam int VEC_W  = LENGTH * INT8;

  typedef enum logic [1:0] {
    WB_NONE    = 2'b00,
    WB_SCALAR  = 2'b01,
    WB_VECTOR  = 2'b10,
    WB_ILLEGAL = 2'b11
  } wb_sel_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_GATHER = 1'b1
  } wb_state_e;
endpackage

// File: rtl/conv_wb_buffer.sv
// One-entry conv result buffer; defers a conv write by one cycle when it
// targets the same register as the pipeline vector write landing that cycle.
module conv_wb_buffer
  import write_back_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             conv_valid,
  output logic             conv_ready,
  input  logic [4:0]       conv_dst,
  input  logic [VEC_W-1:0] conv_data,
  input  logic             pipe_v_write,
  input  logic [4:0]       pipe_rd,
  output logic             conv_write,
  output logic [4:0]       conv_addr,
  output logic [VEC_W-1:0] conv_result
);
  logic             r_full;
  logic             r_ready;
  logic [4:0]       r_dst;
  logic [VEC_W-1:0] r_data;
  logic             r_write;
  logic [4:0]       r_addr;
  logic [VEC_W-1:0] r_result;
  logic             w_accept;
  logic             w_collide;

  assign w_accept  = conv_valid && r_ready;
  assign w_collide = w_accept && pipe_v_write && (pipe_rd == conv_dst);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full   <= 1'b0;
      r_ready  <= 1'b0;
      r_dst    <= '0;
      r_data   <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_result <= '0;
    end else begin
      r_write <= 1'b0;
      if (r_full) begin
        r_write  <= 1'b1;
        r_addr   <= r_dst;
        r_result <= r_data;
        r_full   <= 1'b0;
        r_ready  <= 1'b1;
      end else if (w_collide) begin
        // hold the entry so the pipeline write to the same register lands first
        r_full  <= 1'b1;
        r_dst   <= conv_dst;
        r_data  <= conv_data;
        r_ready <= 1'b0;
      end else begin
        r_ready <= 1'b1;
        if (w_accept) begin
          r_write  <= 1'b1;
          r_addr   <= conv_dst;
          r_result <= conv_data;
        end
      end
    end
  end

  assign conv_ready  = r_ready;
  assign conv_write  = r_write;
  assign conv_addr   = r_addr;
  assign conv_result = r_result;
endmodule

// File: rtl/write_back.sv
// Write-back stage: scalar/vector register-file writes, strided-load gather
// (built only with WB_STRIDE_GATHER_EN) and conv write-port arbitration.
module write_back
  import write_back_pkg::*;
#(
  parameter int LANE_BYTES = LENGTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_wb,
  input  logic [4:0]       in_rD,
  input  logic             in_ldr,
  input  logic [2:0]       strd_cyc,
  input  logic [INT32-1:0] alu_sdata,
  input  logic [VEC_W-1:0] alu_vdata,
  input  logic [INT32-1:0] mem_sdata,
  input  logic [VEC_W-1:0] mem_vdata,
  input  logic             mem_beat,
  input  logic             conv_valid,
  output logic             conv_ready,
  input  logic [4:0]       conv_dst,
  input  logic [VEC_W-1:0] conv_data,
  output logic [4:0]       rD,
  output logic             s_write,
  output logic             v_write,
  output logic [INT32-1:0] swrite_data,
  output logic [VEC_W-1:0] vwrite_data,
  output logic             conv_write,
  output logic [4:0]       conv_addr,
  output logic [VEC_W-1:0] conv_result,
  output logic             stall
);
  logic             w_idle;
  logic             w_is_scalar;
  logic             w_is_vector;
  logic             w_gather_start;
  logic             w_gather_done;
  logic [4:0]       w_g_rd;
  logic [VEC_W-1:0] w_asm_nxt;
  logic             w_v_write_nxt;
  logic [4:0]       w_rd_vec_nxt;
  logic [VEC_W-1:0] w_vdata_nxt;

  logic             r_s_write;
  logic             r_v_write;
  logic [4:0]       r_rd;
  logic [INT32-1:0] r_swrite_data;
  logic [VEC_W-1:0] r_vwrite_data;

  assign w_is_scalar = w_idle && in_valid && (in_wb == WB_SCALAR);
  assign w_is_vector = w_idle && in_valid && (in_wb == WB_VECTOR);

`ifdef WB_STRIDE_GATHER_EN
  localparam int LANE_W = LANE_BYTES * 8;

  wb_state_e        r_state;
  wb_state_e        w_state_nxt;
  logic [2:0]       r_beat_cnt;
  logic [2:0]       r_beat_last;
  logic [4:0]       r_g_rd;
  logic [VEC_W-1:0] r_asm;

  assign w_idle         = (r_state == ST_IDLE);
  assign w_gather_start = w_is_vector && in_ldr && (strd_cyc != 3'd0);
  assign w_g_rd         = r_g_rd;
  assign stall          = (r_state == ST_GATHER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_asm_nxt     = r_asm;
    w_gather_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_gather_start) w_state_nxt = ST_GATHER;
      ST_GATHER: begin
        if (mem_beat) begin
          w_asm_nxt[int'(r_beat_cnt)*LANE_W +: LANE_W] = mem_vdata[int'(r_beat_cnt)*LANE_W +: LANE_W];
          if (r_beat_cnt == r_beat_last) begin
            w_gather_done = 1'b1;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt  <= '0;
      r_beat_last <= '0;
      r_g_rd      <= '0;
      r_asm       <= '0;
    end else if (w_gather_start) begin
      r_beat_cnt  <= '0;
      r_beat_last <= strd_cyc;
      r_g_rd      <= in_rD;
      r_asm       <= '0;
    end else if (r_state == ST_GATHER && mem_beat) begin
      r_beat_cnt <= r_beat_cnt + 3'd1;
      r_asm      <= w_asm_nxt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg   = ^{strd_cyc, mem_beat, LANE_BYTES[0]};
  assign w_idle         = 1'b1;
  assign w_gather_start = 1'b0;
  assign w_gather_done  = 1'b0;
  assign w_g_rd         = '0;
  assign w_asm_nxt      = '0;
  assign stall          = 1'b0;
`endif

  always_comb begin
    w_v_write_nxt = 1'b0;
    w_rd_vec_nxt  = in_rD;
    w_vdata_nxt   = in_ldr ? mem_vdata : alu_vdata;
    if (w_gather_done) begin
      w_v_write_nxt = 1'b1;
      w_rd_vec_nxt  = w_g_rd;
      w_vdata_nxt   = w_asm_nxt;
    end else if (w_is_vector && !w_gather_start) begin
      w_v_write_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s_write     <= 1'b0;
      r_v_write     <= 1'b0;
      r_rd          <= '0;
      r_swrite_data <= '0;
      r_vwrite_data <= '0;
    end else begin
      r_s_write <= w_is_scalar;
      r_v_write <= w_v_write_nxt;
      if (w_is_scalar) begin
        r_rd          <= in_rD;
        r_swrite_data <= in_ldr ? mem_sdata : alu_sdata;
      end
      if (w_v_write_nxt) begin
        r_rd          <= w_rd_vec_nxt;
        r_vwrite_data <= w_vdata_nxt;
      end
    end
  end

  assign s_write     = r_s_write;
  assign v_write     = r_v_write;
  assign rD          = r_rd;
  assign swrite_data = r_swrite_data;
  assign vwrite_data = r_vwrite_data;

  conv_wb_buffer u_conv_buf (
    .clk          (clk),
    .reset        (reset),
    .conv_valid   (conv_valid),
    .conv_ready   (conv_ready),
    .conv_dst     (conv_dst),
    .conv_data    (conv_data),
    .pipe_v_write (w_v_write_nxt),
    .pipe_rd      (w_rd_vec_nxt),
    .conv_write   (conv_write),
    .conv_addr    (conv_addr),
    .conv_result  (conv_result)
  );
endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back; follows WB_STRIDE_GATHER_EN the same way the
// design does (gather behaviour expected only when the macro is defined).
module tb_write_back;
  import write_back_pkg::*;

  localparam int LB = LENGTH / 8;
`ifdef WB_STRIDE_GATHER_EN
  localparam bit GATHER = 1'b1;
`else
  localparam bit GATHER = 1'b0;
`endif

  typedef struct {
    logic             valid;
    logic [1:0]       wb;
    logic [4:0]       rd;
    logic             ldr;
    logic [2:0]       strd;
    logic [31:0]      asd;
    logic [VEC_W-1:0] avd;
    logic [31:0]      msd;
    logic [VEC_W-1:0] mvd;
    logic             beat;
    logic             cv;
    logic [4:0]       cdst;
    logic [VEC_W-1:0] cdata;
  } stim_t;

  typedef struct {
    int               due;
    logic [4:0]       rd;
    logic [VEC_W-1:0] data;
  } exp_t;

  logic clk, reset;
  logic in_valid, in_ldr, mem_beat, conv_valid;
  logic [1:0] in_wb;
  logic [4:0] in_rD, conv_dst;
  logic [2:0] strd_cyc;
  logic [31:0] alu_sdata, mem_sdata;
  logic [VEC_W-1:0] alu_vdata, mem_vdata, conv_data;
  logic conv_ready, s_write, v_write, conv_write, stall;
  logic [4:0] rD, conv_addr;
  logic [31:0] swrite_data;
  logic [VEC_W-1:0] vwrite_data, conv_result;

  write_back dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wb(in_wb), .in_rD(in_rD),
    .in_ldr(in_ldr), .strd_cyc(strd_cyc), .alu_sdata(alu_sdata), .alu_vdata(alu_vdata),
    .mem_sdata(mem_sdata), .mem_vdata(mem_vdata), .mem_beat(mem_beat),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_dst(conv_dst),
    .conv_data(conv_data), .rD(rD), .s_write(s_write), .v_write(v_write),
    .swrite_data(swrite_data), .vwrite_data(vwrite_data), .conv_write(conv_write),
    .conv_addr(conv_addr), .conv_result(conv_result), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sq[$], vq[$], cq[$];

  // reference model state
  bit               m_active = 0;
  int               m_got, m_beats;
  logic [4:0]       m_rd;
  logic [VEC_W-1:0] m_vec;
  bit               m_pending = 0;
  logic [4:0]       m_pdst;
  logic [VEC_W-1:0] m_pdata;
  bit               m_ready = 0;

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{valid: 1'b0, wb: 2'b00, rd: 5'd0, ldr: 1'b0, strd: 3'd0, asd: 32'd0, avd: '0,
          msd: 32'd0, mvd: '0, beat: 1'b0, cv: 1'b0, cdst: 5'd0, cdata: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom % 4) != 0;
    s.wb    = 2'($urandom % 4);
    s.rd    = 5'($urandom % 4);
    s.ldr   = 1'($urandom % 2);
    s.strd  = (($urandom % 3) == 0) ? 3'($urandom % 8) : 3'd0;
    s.asd   = $urandom;
    s.avd   = rand_vec();
    s.msd   = $urandom;
    s.mvd   = rand_vec();
    s.beat  = ($urandom % 4) != 0;
    s.cv    = 1'($urandom % 2);
    s.cdst  = 5'($urandom % 4);
    s.cdata = rand_vec();
    return s;
  endfunction

  task automatic apply(input stim_t s);
    in_valid = s.valid; in_wb = s.wb; in_rD = s.rd; in_ldr = s.ldr; strd_cyc = s.strd;
    alu_sdata = s.asd; alu_vdata = s.avd; mem_sdata = s.msd; mem_vdata = s.mvd;
    mem_beat = s.beat; conv_valid = s.cv; conv_dst = s.cdst; conv_data = s.cdata;
  endtask

  task automatic step(input stim_t s);
    bit pv;
    logic [4:0] prd;
    bit rdy_nxt;
    @(negedge clk);
    #1;
    n_cmp++;
    if (stall !== m_active) begin
      n_fail++;
      $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, m_active);
    end
    n_cmp++;
    if (conv_ready !== m_ready) begin
      n_fail++;
      $display("FAIL conv_ready cyc=%0d got=%b exp=%b", cyc, conv_ready, m_ready);
    end
    apply(s);
    pv = 0;
    prd = '0;
    if (m_active) begin
      if (s.beat) begin
        for (int b = 0; b < LB; b++)
          m_vec[(m_got*LB + b)*8 +: 8] = s.mvd[(m_got*LB + b)*8 +: 8];
        m_got++;
        if (m_got == m_beats) begin
          vq.push_back('{cyc + 1, m_rd, m_vec});
          pv = 1; prd = m_rd; m_active = 0;
        end
      end
    end else if (s.valid) begin
      if (s.wb == 2'b01) begin
        sq.push_back('{cyc + 1, s.rd, {{(VEC_W-32){1'b0}}, (s.ldr ? s.msd : s.asd)}});
      end else if (s.wb == 2'b10) begin
        if (GATHER && s.ldr && s.strd != 3'd0) begin
          m_active = 1; m_rd = s.rd; m_got = 0; m_beats = int'(s.strd) + 1; m_vec = '0;
        end else begin
          vq.push_back('{cyc + 1, s.rd, (s.ldr ? s.mvd : s.avd)});
          pv = 1; prd = s.rd;
        end
      end
    end
    rdy_nxt = 1;
    if (m_pending) begin
      cq.push_back('{cyc + 1, m_pdst, m_pdata});
      m_pending = 0;
    end else if (s.cv && m_ready) begin
      if (pv && prd == s.cdst) begin
        m_pending = 1; m_pdst = s.cdst; m_pdata = s.cdata; rdy_nxt = 0;
      end else begin
        cq.push_back('{cyc + 1, s.cdst, s.cdata});
      end
    end
    m_ready = rdy_nxt;
  endtask

  task automatic check_zero(input string nm);
    n_cmp++;
    if ({s_write, v_write, conv_write, conv_ready, stall, rD, conv_addr,
         swrite_data, vwrite_data, conv_result} !== '0) begin
      n_fail++;
      $display("FAIL %s got s_write=%b v_write=%b conv_write=%b conv_ready=%b stall=%b rD=%0d exp all zero",
               nm, s_write, v_write, conv_write, conv_ready, stall, rD);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1;
    reset = 1'b0;
    apply(idle_stim());
    #1;
    check_zero("reset_outputs");
    sq.delete(); vq.delete(); cq.delete();
    m_active = 0; m_pending = 0; m_ready = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic cmp_write(input string nm, input logic en, input exp_t e,
                           input logic [4:0] a_rd, input logic [VEC_W-1:0] a_d);
    n_cmp++;
    if (!(en === 1'b1 && e.due == cyc && a_rd === e.rd && a_d === e.data)) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got en=%b rd=%0d data=%h exp due=%0d rd=%0d data=%h",
               nm, cyc, en, a_rd, a_d, e.due, e.rd, e.data);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (s_write || (sq.size() > 0 && sq[0].due == cyc)) begin
      e = (sq.size() > 0) ? sq.pop_front() : '{-1, 5'd0, '0};
      cmp_write("scalar_write", s_write, e, rD, {{(VEC_W-32){1'b0}}, swrite_data});
    end
    if (v_write || (vq.size() > 0 && vq[0].due == cyc)) begin
      e = (vq.size() > 0) ? vq.pop_front() : '{-1, 5'd0, '0};
      cmp_write("vector_write", v_write, e, rD, vwrite_data);
    end
    if (conv_write || (cq.size() > 0 && cq[0].due == cyc)) begin
      e = (cq.size() > 0) ? cq.pop_front() : '{-1, 5'd0, '0};
      cmp_write("conv_write", conv_write, e, conv_addr, conv_result);
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    apply(idle_stim());
    #3;
    check_zero("reset_state");
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(idle_stim());

    // scalar ALU write
    s = idle_stim(); s.valid = 1; s.wb = 2'b01; s.rd = 5'd3; s.asd = 32'h1234;
    step(s);
    // scalar load write
    s = idle_stim(); s.valid = 1; s.wb = 2'b01; s.rd = 5'd9; s.ldr = 1; s.msd = 32'hCAFE_0001; s.asd = 32'h1;
    step(s);
    // non-strided vector load of all 0xA5
    s = idle_stim(); s.valid = 1; s.wb = 2'b10; s.rd = 5'd4; s.ldr = 1; s.mvd = {(VEC_W/8){8'hA5}};
    step(s);
    step(idle_stim());
    // strided load strd_cyc=3 with a gap after beat 1
    s = idle_stim(); s.valid = 1; s.wb = 2'b10; s.rd = 5'd12; s.ldr = 1; s.strd = 3'd3; s.mvd = rand_vec();
    step(s);
    for (int i = 0; i < 5; i++) begin
      s = idle_stim(); s.mvd = rand_vec(); s.beat = (i != 2);
      step(s);
    end
    step(idle_stim());
    // vector write and conv result to the same register
    s = idle_stim(); s.valid = 1; s.wb = 2'b10; s.rd = 5'd7; s.avd = rand_vec();
    s.cv = 1; s.cdst = 5'd7; s.cdata = rand_vec();
    step(s);
    s = idle_stim(); s.cv = 1; s.cdst = 5'd2; s.cdata = rand_vec();
    step(s);
    step(s);
    step(idle_stim());
    // illegal select writes nothing
    s = idle_stim(); s.valid = 1; s.wb = 2'b11; s.rd = 5'd5;
    step(s);
    // reset after 2 of 4 strided beats
    s = idle_stim(); s.valid = 1; s.wb = 2'b10; s.rd = 5'd6; s.ldr = 1; s.strd = 3'd3; s.mvd = rand_vec();
    step(s);
    for (int i = 0; i < 2; i++) begin
      s = idle_stim(); s.mvd = rand_vec(); s.beat = 1;
      step(s);
    end
    reset_pulse();
    for (int i = 0; i < 4; i++) step(idle_stim());

    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_pulse();
      step(rand_stim());
    end
    for (int i = 0; i < 6; i++) step(idle_stim());

    n_cmp++;
    if (sq.size() + vq.size() + cq.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected got %0d pending writes exp 0", sq.size() + vq.size() + cq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/write_back.md
# write_back

Write-back stage of the NeuraITek pipeline; the writer side of the register-file write ports that the decode stage reads. Takes the registered execute/memory results, selects scalar or vector write data, and gathers multi-beat strided vector loads into one full vector. It also arbitrates convolution-engine results onto the dedicated conv write port. All register-file write ports are driven from flops.

## Interface
Parameters:
- `LANE_BYTES`, default `` `LENGTH/8 ``: bytes captured per strided beat. `` `LENGTH `` must be divisible by 8.

Ports (`name  direction  width  meaning`):
- `clk  in  1  single clock`
- `reset  in  1  asynchronous, active-low reset`
- `in_valid  in  1  pipeline slot carries an instruction`
- `in_wb  in  2  01 scalar write, 10 vector write, 00 none; 11 illegal, treated as 00`
- `in_rD  in  5  destination register`
- `in_ldr  in  1  data comes from memory rather than ALU`
- `strd_cyc  in  3  strided load: 0 = single beat, k = k+1 beats`
- `alu_sdata  in  `INT32  scalar ALU result`
- `alu_vdata  in  `LENGTH*`INT8  vector ALU result`
- `mem_sdata  in  `INT32  scalar load data`
- `mem_vdata  in  `LENGTH*`INT8  vector load data / current strided beat`
- `mem_beat  in  1  a strided beat is present on mem_vdata`
- `conv_valid  in  1  conv engine offers a result`
- `conv_ready  out  1  write_back accepts a conv result this cycle`
- `conv_dst  in  5  conv destination vector register`
- `conv_data  in  `LENGTH*`INT8  conv result`
- `rD  out  5  write address to both register files`
- `s_write  out  1  scalar register-file write enable`
- `v_write  out  1  vector register-file write enable`
- `swrite_data  out  `INT32  scalar write data`
- `vwrite_data  out  `LENGTH*`INT8  vector write data`
- `conv_write  out  1  conv-port write enable`
- `conv_addr  out  5  conv-port address`
- `conv_result  out  `LENGTH*`INT8  conv-port data`
- `stall  out  1  freeze upstream pipeline registers`

## Operation
- FSM states: IDLE and GATHER.
- **IDLE**
  - A `in_valid` with `in_wb=01` registers `rD`, `swrite_data` and `s_write=1`. Data source: `mem_sdata` if `in_ldr`, else `alu_sdata`.
  - A vector write (`in_wb=10`) with `strd_cyc=0` registers `vwrite_data` and `v_write=1`. Data source: `mem_vdata` if `in_ldr`, else `alu_vdata`.
  - A vector write with `in_ldr && strd_cyc!=0` enters GATHER. It clears the assembly register, loads `beat_cnt=0` and `beat_last=strd_cyc`, latches `in_rD`, and asserts `stall`.
- **GATHER**
  - Each cycle with `mem_beat=1` copies bytes `[beat_cnt*LANE_BYTES +: LANE_BYTES]` of `mem_vdata` into the same lanes of the assembly register, then increments `beat_cnt`. Lanes that receive no beat stay zero.
  - When `beat_cnt==beat_last` and `mem_beat=1`, the next cycle shows `v_write=1`, `vwrite_data` = the full assembly, and the latched `rD`. The FSM returns to IDLE and `stall` deasserts in that same cycle.
  - Beats with `mem_beat=0` are waits; there is no timeout.
- **Conv arbitration**
  - There is a 1-entry conv buffer. `conv_ready = !buf_full`.
  - A conv result is accepted on `conv_valid && conv_ready`.
  - It is written on the next cycle unless that cycle's pipeline `v_write` has `rD==conv_dst`. In that case the conv write is deferred one cycle, so the conv write lands after the pipeline write (program order).
  - While deferred, the buffer is full and `conv_ready=0`.
- Write enables are single-cycle pulses. Data and address outputs hold their last value when the enable is low.

## Timing
- Scalar and non-strided vector writes have 1-cycle latency: `in_valid` at edge n gives the enable high after edge n+1.
- A strided load of k+1 back-to-back beats gives `v_write` one cycle after the last beat. `stall` is high from the cycle after the issue through the last beat.
- Conv results have 1-cycle latency, or 2 cycles on an address collision.
- Reset (async, `reset=0`) clears all outputs to 0, including `conv_ready`. It also forces IDLE and empties the buffer. `conv_ready` returns to 1 on the first clock after release.
- Reset during GATHER discards the partial vector, and no write is issued.
- `in_valid` is ignored while in GATHER, because upstream is stalled.

## Configuration
- `WB_STRIDE_GATHER_EN` defined: GATHER state, assembly register and `stall` are built as described.
- Undefined: `strd_cyc` is ignored, every vector load is single-beat from `mem_vdata`, and `stall` is tied to 0.

## Structure
- Shared package (`def.v`): `` `LENGTH ``, `` `INT8 ``, `` `INT32 ``, plus new `` `WB_NONE `` (00), `` `WB_SCALAR `` (01), `` `WB_VECTOR `` (10) and the FSM state encodings.
- One sub-module, `conv_wb_buffer`: the 1-entry conv buffer with its valid/ready handshake and collision-deferral logic.

## Test plan
1. Scalar ALU write: `in_wb=01`, `in_rD=3`, `alu_sdata=0x1234` → next cycle `s_write=1`, `rD=3`, `swrite_data=0x1234`.
2. Vector load: `in_ldr=1`, `in_wb=10`, `strd_cyc=0`, `mem_vdata=0xA5` in all bytes → `v_write` 1 cycle later with identical data.
3. Strided load: `strd_cyc=3`, four beats with a one-cycle gap after beat 1 → `stall` held 5 cycles. Single `v_write` with lanes 0–3 filled and lanes 4–7 zero.
4. Conv collision: pipeline vector write `rD=7` and `conv_dst=7` in the same cycle → `v_write` first, `conv_write` one cycle later, `conv_ready=0` for one cycle.
5. Reset asserted mid-GATHER after 2 of 4 beats → all outputs 0 immediately. No `v_write` after release; FSM in IDLE.
6. Macro off: `strd_cyc=5` vector load → single-cycle write from `mem_vdata`, `stall` never asserts.
